mem_router: RTL and testbench

Parametrised memory-bus router between the CPU memory port and `SLAVES` memory-mapped slaves such as bram, uart, clint and axi. Each request is decoded against per-slave address windows and registered. A single-cycle valid and a base-relative offset are issued to exactly one slave, which is then tracked until it completes. Unlike a purely combinational decoder, the router returns an error completion for unmapped addresses and for slaves that exceed a timeout, so the CPU never hangs.

---
 rtl/mem_router.sv | 181 ++++++++++++++++++
 tb/tb_mem_router.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_router.sv
// Memory-bus router: decodes each CPU request onto one of SLAVES address windows,
// tracks the selected slave, and returns error completions on decode miss or timeout.
module mem_router #(
  parameter int                            SLAVES     = 4,
  parameter int                            ADDR_WIDTH = 32,
  parameter int                            DATA_WIDTH = 32,
  parameter logic [SLAVES*ADDR_WIDTH-1:0]  BASE_ADDR  = '0,
  parameter logic [SLAVES*ADDR_WIDTH-1:0]  TOP_ADDR   = '0,
  parameter int                            TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          memory_valid,
  input  logic                          memory_instr,
  input  logic [ADDR_WIDTH-1:0]         memory_addr,
  input  logic [DATA_WIDTH-1:0]         memory_wdata,
  input  logic [DATA_WIDTH/8-1:0]       memory_wstrb,
  output logic [DATA_WIDTH-1:0]         memory_rdata,
  output logic                          memory_ready,
  output logic [SLAVES-1:0]             slave_valid,
  output logic                          slave_instr,
  output logic [ADDR_WIDTH-1:0]         slave_addr,
  output logic [DATA_WIDTH-1:0]         slave_wdata,
  output logic [DATA_WIDTH/8-1:0]       slave_wstrb,
  input  logic [SLAVES*DATA_WIDTH-1:0]  slave_rdata,
  input  logic [SLAVES-1:0]             slave_ready,
  output logic                          err_decode,
  output logic                          err_timeout
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int SEL_WIDTH  = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam int CNT_WIDTH  = $clog2(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DERR,
    ST_TOUT
  } state_e;

  state_e                  state_q, state_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [SLAVES-1:0]       valid_q, valid_d;
  logic                    instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;

  logic                    dec_hit;
  logic [SEL_WIDTH-1:0]    dec_sel;
  logic [ADDR_WIDTH-1:0]   dec_offset;
  logic                    sel_ready;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic                    accept;

  function automatic logic [ADDR_WIDTH-1:0] win_base(input int idx);
    return BASE_ADDR[idx*ADDR_WIDTH +: ADDR_WIDTH];
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] win_top(input int idx);
    return TOP_ADDR[idx*ADDR_WIDTH +: ADDR_WIDTH];
  endfunction

  // Scanning from the highest index down lets the lowest matching window win.
  always_comb begin
    dec_hit    = 1'b0;
    dec_sel    = '0;
    dec_offset = '0;
    for (int i = SLAVES - 1; i >= 0; i--) begin
      if ((win_base(i) < win_top(i)) &&
          (memory_addr >= win_base(i)) && (memory_addr < win_top(i))) begin
        dec_hit    = 1'b1;
        dec_sel    = SEL_WIDTH'(i);
        dec_offset = memory_addr - win_base(i);
      end
    end
  end

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < SLAVES; i++) begin
      if (sel_q == SEL_WIDTH'(i)) begin
        sel_ready = slave_ready[i];
        sel_rdata = slave_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign accept = memory_valid && ((state_q != ST_BUSY) || sel_ready);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    valid_d      = '0;
    instr_d      = instr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    memory_ready = 1'b0;
    memory_rdata = '0;
    err_decode   = 1'b0;
    err_timeout  = 1'b0;

    case (state_q)
      ST_BUSY: begin
        memory_ready = sel_ready;
        memory_rdata = sel_rdata;
        if (sel_ready) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_TOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DERR: begin
        memory_ready = 1'b1;
        err_decode   = 1'b1;
        state_d      = ST_IDLE;
      end
      ST_TOUT: begin
        memory_ready = 1'b1;
        err_timeout  = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A request accepted in a completion cycle overrides the return to idle.
    if (accept) begin
      if (dec_hit) begin
        state_d = ST_BUSY;
        sel_d   = dec_sel;
        cnt_d   = '0;
        valid_d = SLAVES'(1) << dec_sel;
        instr_d = memory_instr;
        addr_d  = dec_offset;
        wdata_d = memory_wdata;
        wstrb_d = memory_wstrb;
      end else begin
        state_d = ST_DERR;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      valid_q <= '0;
      instr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign slave_valid = valid_q;
  assign slave_instr = instr_q;
  assign slave_addr  = addr_q;
  assign slave_wdata = wdata_q;
  assign slave_wstrb = wstrb_q;

endmodule

// File: tb/tb_mem_router.sv
// Self-checking bench for mem_router: a transaction-level planner predicts every
// output per cycle from the address windows; two instances cover plain and overlapping maps.
module tb_mem_router;

  localparam int T    = 8;
  localparam int MAXC = 8192;

  localparam logic [127:0] BASE0 = {32'h8000_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000};
  localparam logic [127:0] TOP0  = {32'hC000_0000, 32'h0200_C000, 32'h0100_0010, 32'h0001_0000};
  localparam logic [127:0] BASE1 = {32'hFFFF_0000, 32'h0000_5000, 32'h0000_1800, 32'h0000_1000};
  localparam logic [127:0] TOP1  = {32'hFFFF_FFFF, 32'h0000_5000, 32'h0000_3000, 32'h0000_2000};

  typedef struct packed {
    logic [3:0]  valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    logic        ready;
    logic [31:0] rdata;
    logic        derr;
    logic        tout;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst  [2];
  logic         mv   [2];
  logic         mi   [2];
  logic [31:0]  ma   [2];
  logic [31:0]  mwd  [2];
  logic [3:0]   mws  [2];
  logic [127:0] srd  [2];
  logic [3:0]   srdy [2];

  logic [31:0]  o_rdata [2];
  logic         o_ready [2];
  logic [3:0]   o_sv    [2];
  logic         o_si    [2];
  logic [31:0]  o_sa    [2];
  logic [31:0]  o_swd   [2];
  logic [3:0]   o_sws   [2];
  logic         o_derr  [2];
  logic         o_tout  [2];

  exp_t         exp_q   [2][MAXC];
  logic [3:0]   h_valid [2][MAXC];
  logic [31:0]  h_addr  [2][MAXC];
  logic [3:0]   h_wstrb [2][MAXC];
  logic         h_ready [2][MAXC];
  logic [31:0]  h_rdata [2][MAXC];
  logic         h_derr  [2][MAXC];
  logic         h_tout  [2][MAXC];

  logic [31:0]  wb [2][4];
  logic [31:0]  wt [2][4];

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en   = 1'b0;

  mem_router #(
    .SLAVES(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .BASE_ADDR(BASE0), .TOP_ADDR(TOP0), .TIMEOUT(T)
  ) u_dut0 (
    .clk(clk), .rst(rst[0]),
    .memory_valid(mv[0]), .memory_instr(mi[0]), .memory_addr(ma[0]),
    .memory_wdata(mwd[0]), .memory_wstrb(mws[0]),
    .memory_rdata(o_rdata[0]), .memory_ready(o_ready[0]),
    .slave_valid(o_sv[0]), .slave_instr(o_si[0]), .slave_addr(o_sa[0]),
    .slave_wdata(o_swd[0]), .slave_wstrb(o_sws[0]),
    .slave_rdata(srd[0]), .slave_ready(srdy[0]),
    .err_decode(o_derr[0]), .err_timeout(o_tout[0])
  );

  mem_router #(
    .SLAVES(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .BASE_ADDR(BASE1), .TOP_ADDR(TOP1), .TIMEOUT(T)
  ) u_dut1 (
    .clk(clk), .rst(rst[1]),
    .memory_valid(mv[1]), .memory_instr(mi[1]), .memory_addr(ma[1]),
    .memory_wdata(mwd[1]), .memory_wstrb(mws[1]),
    .memory_rdata(o_rdata[1]), .memory_ready(o_ready[1]),
    .slave_valid(o_sv[1]), .slave_instr(o_si[1]), .slave_addr(o_sa[1]),
    .slave_wdata(o_swd[1]), .slave_wstrb(o_sws[1]),
    .slave_rdata(srd[1]), .slave_ready(srdy[1]),
    .err_decode(o_derr[1]), .err_timeout(o_tout[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, expv);
    end
  endtask

  // Window lookup straight from the address map: first enabled window containing a wins.
  function automatic int mdl_decode(input int k, input logic [31:0] a, output logic [31:0] off);
    off = '0;
    for (int i = 0; i < 4; i++) begin
      if (wb[k][i] < wt[k][i] && a >= wb[k][i] && a < wt[k][i]) begin
        off = a - wb[k][i];
        return i;
      end
    end
    return -1;
  endfunction

  function automatic logic [31:0] pick_addr(input int k);
    int w;
    logic [31:0] b, t;
    w = $urandom_range(0, 3);
    b = wb[k][w];
    t = wt[k][w];
    case ($urandom_range(0, 5))
      0: return b;
      1: return t - 1;
      2: return t;
      3: return b - 1;
      4: return (t > b) ? b + ($urandom % (t - b)) : b;
      default: return $urandom;
    endcase
  endfunction

  task automatic compare_unit(input int k);
    if (cmp_en && cyc < MAXC) begin
      h_valid[k][cyc] = o_sv[k];
      h_addr[k][cyc]  = o_sa[k];
      h_wstrb[k][cyc] = o_sws[k];
      h_ready[k][cyc] = o_ready[k];
      h_rdata[k][cyc] = o_rdata[k];
      h_derr[k][cyc]  = o_derr[k];
      h_tout[k][cyc]  = o_tout[k];
      check($sformatf("u%0d.slave_valid", k), 64'(o_sv[k]), 64'(exp_q[k][cyc].valid));
      check($sformatf("u%0d.memory_ready", k), 64'(o_ready[k]), 64'(exp_q[k][cyc].ready));
      check($sformatf("u%0d.err_decode", k), 64'(o_derr[k]), 64'(exp_q[k][cyc].derr));
      check($sformatf("u%0d.err_timeout", k), 64'(o_tout[k]), 64'(exp_q[k][cyc].tout));
      if (exp_q[k][cyc].ready)
        check($sformatf("u%0d.memory_rdata", k), 64'(o_rdata[k]), 64'(exp_q[k][cyc].rdata));
      if (exp_q[k][cyc].valid != 4'd0) begin
        check($sformatf("u%0d.slave_addr", k), 64'(o_sa[k]), 64'(exp_q[k][cyc].addr));
        check($sformatf("u%0d.slave_wdata", k), 64'(o_swd[k]), 64'(exp_q[k][cyc].wdata));
        check($sformatf("u%0d.slave_wstrb", k), 64'(o_sws[k]), 64'(exp_q[k][cyc].wstrb));
        check($sformatf("u%0d.slave_instr", k), 64'(o_si[k]), 64'(exp_q[k][cyc].instr));
      end
    end
  endtask

  always @(negedge clk) begin
    compare_unit(0);
    compare_unit(1);
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      mv[k]   = 1'b0;
      srdy[k] = 4'd0;
      mi[k]   = 1'($urandom);
      ma[k]   = $urandom;
      mwd[k]  = $urandom;
      mws[k]  = 4'($urandom);
      srd[k]  = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // Presents one request in the current cycle, plans its expected outputs and plays
  // the slave side. d >= T means the slave never answers. Returns in the completion
  // cycle (or the cycle after a timeout when a late ready is injected).
  task automatic run_txn(input int k, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input logic ins, input int d,
                         input bit late, input bit strays, input logic [31:0] rv);
    int c, sel;
    logic [31:0] off;
    c = cyc;
    mv[k]  = 1'b1;
    ma[k]  = a;
    mwd[k] = wd;
    mws[k] = ws;
    mi[k]  = ins;
    sel = mdl_decode(k, a, off);
    if (sel < 0) begin
      exp_q[k][c+1].ready = 1'b1;
      exp_q[k][c+1].derr  = 1'b1;
      next_cycle();
      return;
    end
    exp_q[k][c+1].valid = 4'(1) << sel;
    exp_q[k][c+1].addr  = off;
    exp_q[k][c+1].wdata = wd;
    exp_q[k][c+1].wstrb = ws;
    exp_q[k][c+1].instr = ins;
    next_cycle();
    for (int j = 0; j < d && j < T; j++) begin
      if (strays) srdy[k] = 4'($urandom) & ~(4'(1) << sel);
      next_cycle();
    end
    if (d < T) begin
      if (strays) srdy[k] = 4'($urandom);
      srdy[k][sel] = 1'b1;
      srd[k][sel*32 +: 32] = rv;
      exp_q[k][cyc].ready = 1'b1;
      exp_q[k][cyc].rdata = rv;
    end else begin
      exp_q[k][cyc].ready = 1'b1;
      exp_q[k][cyc].tout  = 1'b1;
      if (late) begin
        next_cycle();
        srdy[k][sel] = 1'b1;
      end
    end
  endtask

  initial begin
    int c0, c1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        wb[k][i] = (k == 0) ? BASE0[i*32 +: 32] : BASE1[i*32 +: 32];
        wt[k][i] = (k == 0) ? TOP0[i*32 +: 32]  : TOP1[i*32 +: 32];
      end
      for (int c = 0; c < MAXC; c++) exp_q[k][c] = '0;
      rst[k] = 1'b1; mv[k] = 1'b0; mi[k] = 1'b0; ma[k] = '0;
      mwd[k] = '0; mws[k] = '0; srd[k] = '0; srdy[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    cmp_en = 1'b1;
    #2;
    check("reset.slave_valid", 64'(o_sv[0]), 64'h0);
    check("reset.memory_ready", 64'(o_ready[0]), 64'h0);
    check("reset.memory_rdata", 64'(o_rdata[0]), 64'h0);
    check("reset.err_decode", 64'(o_derr[0]), 64'h0);
    check("reset.err_timeout", 64'(o_tout[0]), 64'h0);
    check("reset.slave_addr", 64'(o_sa[0]), 64'h0);
    check("reset.slave_wdata", 64'(o_swd[0]), 64'h0);
    check("reset.slave_wstrb", 64'(o_sws[0]), 64'h0);
    check("reset.slave_instr", 64'(o_si[0]), 64'h0);
    next_cycle();

    // Basic read of slave 1, ready three cycles after slave_valid.
    c0 = cyc;
    run_txn(0, 32'h0100_0004, 32'h0, 4'h0, 1'b0, 3, 1'b0, 1'b0, 32'hDEAD_BEEF);
    next_cycle();
    check("read.slave_valid", 64'(h_valid[0][c0+1]), 64'h2);
    check("read.slave_addr", 64'(h_addr[0][c0+1]), 64'h4);
    check("read.valid_one_cycle", 64'(h_valid[0][c0+2]), 64'h0);
    check("read.not_ready_early", 64'(h_ready[0][c0+3]), 64'h0);
    check("read.memory_ready", 64'(h_ready[0][c0+4]), 64'h1);
    check("read.memory_rdata", 64'(h_rdata[0][c0+4]), 64'hDEAD_BEEF);

    // Unmapped address.
    c0 = cyc;
    run_txn(0, 32'h3000_0000, 32'h0, 4'h0, 1'b0, 0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    check("unmapped.no_valid", 64'(h_valid[0][c0+1]), 64'h0);
    check("unmapped.memory_ready", 64'(h_ready[0][c0+1]), 64'h1);
    check("unmapped.err_decode", 64'(h_derr[0][c0+1]), 64'h1);
    check("unmapped.memory_rdata", 64'(h_rdata[0][c0+1]), 64'h0);

    // Timeout on slave 3, then a late ready while idle.
    c0 = cyc;
    run_txn(0, 32'h8000_0000, 32'h0, 4'h0, 1'b0, T + 3, 1'b1, 1'b0, 32'h0);
    next_cycle();
    check("timeout.slave_valid", 64'(h_valid[0][c0+1]), 64'h8);
    check("timeout.not_early", 64'(h_ready[0][c0+8]), 64'h0);
    check("timeout.memory_ready", 64'(h_ready[0][c0+9]), 64'h1);
    check("timeout.err_timeout", 64'(h_tout[0][c0+9]), 64'h1);
    check("timeout.late_ready_dropped", 64'(h_ready[0][c0+10]), 64'h0);

    // Back-to-back: zero-latency read, then a write presented in its ready cycle.
    c0 = cyc;
    run_txn(0, 32'h0200_0000, 32'h0, 4'h0, 1'b0, 0, 1'b0, 1'b0, 32'h1234_5678);
    c1 = cyc;
    run_txn(0, 32'h8000_0010, 32'hCAFE_F00D, 4'b0011, 1'b0, 1, 1'b0, 1'b0, 32'h0);
    next_cycle();
    check("b2b.first_ready_with_valid", 64'(h_ready[0][c0+1]), 64'h1);
    check("b2b.second_valid", 64'(h_valid[0][c0+2]), 64'h8);
    check("b2b.write_addr", 64'(h_addr[0][c1+1]), 64'h10);
    check("b2b.write_wstrb", 64'(h_wstrb[0][c1+1]), 64'h3);

    // Overlapping windows on the second map; strays from other slaves ignored.
    c0 = cyc;
    run_txn(1, 32'h0000_1900, 32'h0, 4'h0, 1'b1, 4, 1'b0, 1'b1, 32'h0BAD_CAFE);
    next_cycle();
    check("overlap.slave_valid", 64'(h_valid[1][c0+1]), 64'h1);
    check("overlap.slave_addr", 64'(h_addr[1][c0+1]), 64'h900);
    check("overlap.no_stray_ready", 64'(h_ready[1][c0+4]), 64'h0);
    check("overlap.memory_rdata", 64'(h_rdata[1][c0+5]), 64'h0BAD_CAFE);
    c0 = cyc;
    run_txn(1, 32'h0000_5000, 32'h0, 4'h0, 1'b0, 0, 1'b0, 1'b0, 32'h0);
    next_cycle();
    check("disabled.err_decode", 64'(h_derr[1][c0+1]), 64'h1);

    // Reset while busy on slave 2: no completion, fields cleared, then normal traffic.
    c0 = cyc;
    mv[0] = 1'b1; ma[0] = 32'h0200_0100; mwd[0] = 32'h5555_AAAA; mws[0] = 4'hF; mi[0] = 1'b1;
    exp_q[0][c0+1].valid = 4'b0100;
    exp_q[0][c0+1].addr  = 32'h100;
    exp_q[0][c0+1].wdata = 32'h5555_AAAA;
    exp_q[0][c0+1].wstrb = 4'hF;
    exp_q[0][c0+1].instr = 1'b1;
    next_cycle();
    next_cycle();
    rst[0] = 1'b1;
    next_cycle();
    rst[0] = 1'b0;
    srdy[0][2] = 1'b1;
    next_cycle();
    check("rst_busy.slave_valid", 64'(h_valid[0][c0+3]), 64'h0);
    check("rst_busy.slave_addr", 64'(h_addr[0][c0+3]), 64'h0);
    check("rst_busy.no_completion", 64'(h_ready[0][c0+3]), 64'h0);
    c0 = cyc;
    run_txn(0, 32'h0000_0040, 32'h0, 4'h0, 1'b0, 2, 1'b0, 1'b0, 32'h7777_0001);
    next_cycle();
    check("after_rst.slave_valid", 64'(h_valid[0][c0+1]), 64'h1);
    check("after_rst.memory_rdata", 64'(h_rdata[0][c0+3]), 64'h7777_0001);

    // Randomized traffic on both maps against the planner.
    for (int n = 0; n < 400 && cyc < MAXC - 3 * T; n++) begin
      int k;
      k = $urandom_range(0, 1);
      run_txn(k, pick_addr(k), $urandom, 4'($urandom), 1'($urandom),
              $urandom_range(0, T + 2), 1'($urandom), 1'($urandom), $urandom);
      repeat ($urandom_range(0, 2)) next_cycle();
    end
    next_cycle();
    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
